jam_perm_search: RTL and testbench
==================================

// Module: jam_perm_search
// PURPOSE
//  Parametrised exhaustive job-assignment engine: enumerates all N! worker->job permutations in
//  lexicographic order, reads each W/J cost from an external cost table, accumulates per-permutation
//  totals, tracks the minimum total and how many permutations reach it. Successor of the fixed 8x8
//  assignment engine: adds N/width parameters, Start/Busy handshake, re-runnability, best-permutation output.
// PARAMETERS
//  N      8   workers = jobs; legal range 2..8
//  CW     7   Cost input width (unsigned)
//  TW     10  total/MinCost width; must be >= CW+clog2(N)
//  IW     3   W/J index width (localparam, clog2(N), min 1)
//  MW     16  MatchCount width (localparam; N! <= 40320 fits)
// PORTS
//  CLK         in   1      clock, rising edge
//  RST_N       in   1      asynchronous active-low reset
//  Start       in   1      run request; sampled only in IDLE
//  Busy        out  1      high from Start acceptance until DONE cycle ends
//  W           out  IW     worker index presented to cost table
//  J           out  IW     job index presented to cost table
//  Cost        in   CW     cost of (W,J) driven on previous cycle
//  MinCost     out  TW     minimum total found
//  MatchCount  out  MW     permutations achieving MinCost
//  Valid       out  1      one-cycle pulse: results final
//  BestPerm    out  N*IW   [BEST_PERM_EN only] first minimal permutation, job of worker k at [k*IW+:IW]
// BEHAVIOUR
//  Reset (async, RST_N=0): state IDLE, W=0, J=0, MinCost=all-ones, MatchCount=0, Valid=0, Busy=0,
//   perm=identity, BestPerm=identity. Reset mid-run aborts at once; no Valid; next Start runs clean.
//  FSM: IDLE -> RUN -> CMP -> (RUN | DONE) -> IDLE.
//  IDLE: Start=1 at edge -> RUN; clears MinCost=all-ones, MatchCount=0, perm=identity, sum=0, k=0; Busy=1.
//  RUN (N+1 cycles, counter k=0..N): k<N drives W=k, J=perm[k]; k>=1 adds Cost to sum (zero-extended
//   to TW). At k=N, last Cost added, W=J=0, -> CMP. Start ignored outside IDLE.
//  CMP (1 cycle): sum<MinCost -> MinCost=sum, MatchCount=1, BestPerm=perm; sum==MinCost ->
//   MatchCount+1; else hold. Ties never replace BestPerm (first = lexicographically smallest).
//   perm <= next lexicographic permutation (pivot = rightmost i with perm[i]<perm[i+1]; swap with
//   rightmost larger element; reverse suffix), single-cycle combinational. No pivot (descending) ->
//   DONE with Valid<=1 on this edge; else -> RUN, sum=0, k=0.
//  DONE (1 cycle): Valid=1, Busy=1; next edge Valid=0, Busy=0, IDLE. Results held until next Start.
//  Timing: N+2 cycles/permutation; Valid rises N!*(N+2) edges after the Start-accepting edge
//   (N=8: 403200; N=3: 30).
//  Arithmetic: unsigned; no overflow for legal TW; MatchCount no wrap for N<=8.
//  W/J outside RUN driving cycles = 0.
// CONFIGURATION
//  BEST_PERM_EN defined: BestPerm port and register present, updated per CMP rule above.
//  BEST_PERM_EN undefined: port and register absent; all other behaviour, timing identical.
// TESTING
//  N=8, Cost=(W==J)?0:10 -> MinCost=0, MatchCount=1, BestPerm=identity {0..7}, Valid at edge 403200.
//  N=8, Cost=5 everywhere -> MinCost=40, MatchCount=40320, BestPerm=identity.
//  N=3, Cost=W*J -> MinCost=1, MatchCount=1, BestPerm={2,1,0}, Valid exactly 30 edges after Start.
//  N=8, RST_N low 1 cycle at cycle 1000 of run -> all outputs reset values, Valid never pulses;
//   new Start then gives correct result.
//  Start pulsed during RUN and DONE -> ignored, single Valid; Start held high -> back-to-back runs,
//   identical results.
//  Build without BEST_PERM_EN, rerun test 3 -> MinCost=1, MatchCount=1, same Valid timing.

Source files
------------

// File: rtl/jam_perm_search.sv
// jam_perm_search: exhaustive worker->job assignment search over all N! permutations in lexicographic order.
// Optional macro BEST_PERM_EN adds the BestPerm output holding the first minimal permutation.
module jam_perm_search #(
    parameter int N  = 8,
    parameter int CW = 7,
    parameter int TW = 10,
    localparam int IW = (N > 1) ? $clog2(N) : 1,
    localparam int MW = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          Start,
    output logic          Busy,
    output logic [IW-1:0] W,
    output logic [IW-1:0] J,
    input  logic [CW-1:0] Cost,
    output logic [TW-1:0] MinCost,
    output logic [MW-1:0] MatchCount,
    output logic          Valid
`ifdef BEST_PERM_EN
    ,
    output logic [N*IW-1:0] BestPerm
`endif
);
    localparam int KW = $clog2(N + 1);
    localparam int PW = N * IW;
    localparam logic [KW-1:0] KN = KW'(N);

    typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

    function automatic logic [PW-1:0] ident();
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i*IW+:IW] = IW'(i);
        return p;
    endfunction

    state_t state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [TW-1:0] sum_q, sum_d, min_q, min_d;
    logic [MW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] perm_q, perm_d, perm_nxt, swp;
    logic has_piv;
    int piv, sw;
`ifdef BEST_PERM_EN
    logic [PW-1:0] best_q, best_d;
    assign BestPerm = best_q;
`endif

    // Successor permutation: swap pivot with rightmost larger element, then reverse the suffix
    always_comb begin
        piv = 0;
        sw = 0;
        has_piv = 1'b0;
        for (int i = 0; i < N - 1; i++)
            if (perm_q[i*IW+:IW] < perm_q[(i+1)*IW+:IW]) begin
                piv = i;
                has_piv = 1'b1;
            end
        sw = piv;
        for (int i = 0; i < N; i++)
            if (i > piv && perm_q[i*IW+:IW] > perm_q[piv*IW+:IW]) sw = i;
        swp = perm_q;
        swp[piv*IW+:IW] = perm_q[sw*IW+:IW];
        swp[sw*IW+:IW] = perm_q[piv*IW+:IW];
        perm_nxt = swp;
        for (int i = 0; i < N; i++)
            if (i > piv) perm_nxt[i*IW+:IW] = swp[(N+piv-i)*IW+:IW];
    end

    always_comb begin
        state_d = state_q;
        k_d = k_q;
        sum_d = sum_q;
        min_d = min_q;
        cnt_d = cnt_q;
        perm_d = perm_q;
`ifdef BEST_PERM_EN
        best_d = best_q;
`endif
        case (state_q)
            IDLE: if (Start) begin
                state_d = RUN;
                min_d = '1;
                cnt_d = '0;
                perm_d = ident();
                sum_d = '0;
                k_d = '0;
            end
            RUN: begin
                sum_d = (k_q != '0) ? sum_q + TW'(Cost) : sum_q;
                k_d = (k_q == KN) ? '0 : k_q + 1'b1;
                state_d = (k_q == KN) ? CMP : RUN;
            end
            CMP: begin
                if (sum_q < min_q) begin
                    min_d = sum_q;
                    cnt_d = MW'(1);
`ifdef BEST_PERM_EN
                    best_d = perm_q;
`endif
                end else if (sum_q == min_q) cnt_d = cnt_q + 1'b1;
                perm_d = has_piv ? perm_nxt : perm_q;
                state_d = has_piv ? RUN : DONE;
                sum_d = '0;
                k_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N)
        if (!RST_N) begin
            state_q <= IDLE;
            k_q <= '0;
            sum_q <= '0;
            min_q <= '1;
            cnt_q <= '0;
            perm_q <= ident();
`ifdef BEST_PERM_EN
            best_q <= ident();
`endif
        end else begin
            state_q <= state_d;
            k_q <= k_d;
            sum_q <= sum_d;
            min_q <= min_d;
            cnt_q <= cnt_d;
            perm_q <= perm_d;
`ifdef BEST_PERM_EN
            best_q <= best_d;
`endif
        end

    always_comb begin
        W = '0;
        J = '0;
        if (state_q == RUN && k_q != KN) begin
            W = IW'(k_q);
            for (int i = 0; i < N; i++)
                if (k_q == KW'(i)) J = perm_q[i*IW+:IW];
        end
    end

    assign Busy = state_q != IDLE;
    assign Valid = state_q == DONE;
    assign MinCost = min_q;
    assign MatchCount = cnt_q;
endmodule

// File: tb/tb_jam_perm_search.sv
// tb_jam_perm_search: randomized cost tables checked against a brute-force assignment model (N=4).
module tb_jam_perm_search;
    localparam int N = 4, CW = 7, TW = 10, IW = 2, MW = 16, PW = N * IW;
    localparam int LAT = 24 * (N + 2);

    logic CLK = 1'b0, RST_N = 1'b0, Start = 1'b0;
    logic Busy, Valid;
    logic [IW-1:0] W, J;
    logic [CW-1:0] Cost;
    logic [TW-1:0] MinCost;
    logic [MW-1:0] MatchCount;
`ifdef BEST_PERM_EN
    logic [PW-1:0] BestPerm;
`endif

    int tests = 0, fails = 0;
    logic [CW-1:0] cost_tab [N][N];
    int exp_min, exp_cnt;
    logic [PW-1:0] exp_best, ident_p;

    jam_perm_search #(.N(N), .CW(CW), .TW(TW)) dut (
        .CLK(CLK), .RST_N(RST_N), .Start(Start), .Busy(Busy), .W(W), .J(J), .Cost(Cost),
        .MinCost(MinCost), .MatchCount(MatchCount), .Valid(Valid)
`ifdef BEST_PERM_EN
        , .BestPerm(BestPerm)
`endif
    );

    always #5 CLK = ~CLK;

    // Registered cost table: Cost answers the (W,J) of the previous cycle
    always @(posedge CLK) Cost <= cost_tab[W][J];

    task automatic set_table(input int mode);
        for (int w = 0; w < N; w++)
            for (int j = 0; j < N; j++)
                case (mode)
                    0: cost_tab[w][j] = (w == j) ? 7'd0 : 7'd10;
                    1: cost_tab[w][j] = 7'd5;
                    2: cost_tab[w][j] = CW'(w * j);
                    3: cost_tab[w][j] = CW'($urandom_range(0, 3));
                    default: cost_tab[w][j] = CW'($urandom_range(0, 127));
                endcase
    endtask

    // Brute force: count through all N^N digit strings in ascending order, keep only permutations
    task automatic model();
        int d, used, ok, tot;
        logic [PW-1:0] p;
        exp_min = (1 << TW) - 1;
        exp_cnt = 0;
        exp_best = ident_p;
        for (int c = 0; c < N ** N; c++) begin
            used = 0; ok = 1; tot = 0; p = '0;
            for (int w = 0; w < N; w++) begin
                d = (c / (N ** (N - 1 - w))) % N;
                if ((used >> d) & 1) ok = 0;
                used = used | (1 << d);
                tot += int'(cost_tab[w][d]);
                p[w*IW+:IW] = IW'(d);
            end
            if (ok == 1) begin
                if (tot < exp_min) begin
                    exp_min = tot; exp_cnt = 1; exp_best = p;
                end else if (tot == exp_min) exp_cnt++;
            end
        end
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!Valid && lat < LAT + 40) begin
            @(posedge CLK); #1; lat++;
        end
    endtask

    task automatic do_run(output int lat);
        @(negedge CLK); Start = 1'b1;
        @(posedge CLK); #1; Start = 1'b0;
        wait_valid(lat);
    endtask

    task automatic check_results(input string tag, input int lat);
        tests++;
        if (lat !== LAT) begin fails++; $display("FAIL %s latency got %0d want %0d", tag, lat, LAT); end
        tests++;
        if (MinCost !== TW'(exp_min)) begin fails++; $display("FAIL %s MinCost got %0d want %0d", tag, MinCost, exp_min); end
        tests++;
        if (MatchCount !== MW'(exp_cnt)) begin fails++; $display("FAIL %s MatchCount got %0d want %0d", tag, MatchCount, exp_cnt); end
        tests++;
        if (Busy !== 1'b1) begin fails++; $display("FAIL %s Busy at Valid got %b want 1", tag, Busy); end
`ifdef BEST_PERM_EN
        tests++;
        if (BestPerm !== exp_best) begin fails++; $display("FAIL %s BestPerm got %h want %h", tag, BestPerm, exp_best); end
`endif
        @(posedge CLK); #1;
        tests++;
        if (Valid !== 1'b0 || Busy !== 1'b0) begin fails++; $display("FAIL %s after-done Valid/Busy got %b%b want 00", tag, Valid, Busy); end
        tests++;
        if (MinCost !== TW'(exp_min)) begin fails++; $display("FAIL %s held MinCost got %0d want %0d", tag, MinCost, exp_min); end
    endtask

    task automatic check_reset_vals(input string tag);
        tests++;
        if (Busy !== 1'b0 || Valid !== 1'b0) begin fails++; $display("FAIL %s Busy/Valid got %b%b want 00", tag, Busy, Valid); end
        tests++;
        if (MinCost !== '1 || MatchCount !== '0) begin fails++; $display("FAIL %s MinCost/MatchCount got %0d/%0d want %0d/0", tag, MinCost, MatchCount, (1 << TW) - 1); end
        tests++;
        if (W !== '0 || J !== '0) begin fails++; $display("FAIL %s W/J got %0d/%0d want 0/0", tag, W, J); end
`ifdef BEST_PERM_EN
        tests++;
        if (BestPerm !== ident_p) begin fails++; $display("FAIL %s BestPerm got %h want %h", tag, BestPerm, ident_p); end
`endif
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_reset_vals("reset");
        @(negedge CLK); RST_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("idle");
    endtask

    task automatic test_patterns();
        int lat;
        for (int m = 0; m < 8; m++) begin
            set_table(m < 3 ? m : (m < 6 ? 3 : 4));
            model();
            do_run(lat);
            check_results($sformatf("pattern%0d", m), lat);
        end
    endtask

    task automatic test_start_ignored();
        int lat, nv;
        set_table(3);
        model();
        @(negedge CLK); Start = 1'b1;
        @(posedge CLK); #1; Start = 1'b0;
        repeat (10) @(posedge CLK);
        #1; Start = 1'b1;
        @(posedge CLK); #1; Start = 1'b0;
        lat = 11;
        while (!Valid && lat < LAT + 40) begin @(posedge CLK); #1; lat++; end
        tests++;
        if (lat !== LAT) begin fails++; $display("FAIL ignore_run latency got %0d want %0d", lat, LAT); end
        tests++;
        if (MatchCount !== MW'(exp_cnt) || MinCost !== TW'(exp_min)) begin
            fails++; $display("FAIL ignore_run result got %0d/%0d want %0d/%0d", MinCost, MatchCount, exp_min, exp_cnt);
        end
        Start = 1'b1;
        @(posedge CLK); #1; Start = 1'b0;
        nv = 0;
        repeat (LAT + 20) begin @(posedge CLK); #1; if (Valid || Busy) nv++; end
        tests++;
        if (nv !== 0) begin fails++; $display("FAIL ignore_done extra activity got %0d cycles want 0", nv); end
    endtask

    task automatic test_reset_mid();
        int lat, nv;
        set_table(4);
        model();
        @(negedge CLK); Start = 1'b1;
        @(posedge CLK); #1; Start = 1'b0;
        repeat (60) @(posedge CLK);
        @(negedge CLK); RST_N = 1'b0;
        #2;
        check_reset_vals("midreset");
        @(negedge CLK); RST_N = 1'b1;
        nv = 0;
        repeat (LAT + 20) begin @(posedge CLK); #1; if (Valid) nv++; end
        tests++;
        if (nv !== 0) begin fails++; $display("FAIL midreset Valid pulses got %0d want 0", nv); end
        do_run(lat);
        check_results("after_reset", lat);
    endtask

    task automatic test_back_to_back();
        int lat, n;
        set_table(3);
        model();
        @(negedge CLK); Start = 1'b1;
        @(posedge CLK); #1;
        wait_valid(lat);
        tests++;
        if (lat !== LAT || MinCost !== TW'(exp_min) || MatchCount !== MW'(exp_cnt)) begin
            fails++; $display("FAIL b2b first got lat=%0d %0d/%0d want lat=%0d %0d/%0d", lat, MinCost, MatchCount, LAT, exp_min, exp_cnt);
        end
        @(posedge CLK); #1; n = 1;
        while (!Valid && n < LAT + 40) begin @(posedge CLK); #1; n++; end
        Start = 1'b0;
        tests++;
        if (n !== LAT + 2) begin fails++; $display("FAIL b2b interval got %0d want %0d", n, LAT + 2); end
        tests++;
        if (MinCost !== TW'(exp_min) || MatchCount !== MW'(exp_cnt)) begin
            fails++; $display("FAIL b2b second got %0d/%0d want %0d/%0d", MinCost, MatchCount, exp_min, exp_cnt);
        end
`ifdef BEST_PERM_EN
        tests++;
        if (BestPerm !== exp_best) begin fails++; $display("FAIL b2b BestPerm got %h want %h", BestPerm, exp_best); end
`endif
        repeat (3) @(posedge CLK);
        #1;
        tests++;
        if (Busy !== 1'b0) begin fails++; $display("FAIL b2b stop Busy got %b want 0", Busy); end
    endtask

    initial begin
        for (int i = 0; i < N; i++) ident_p[i*IW+:IW] = IW'(i);
        set_table(0);
        test_reset();
        test_patterns();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
